// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution unit: ARM condition codes
// and the bit positions of N, Z, C and V inside the 4-bit flag word.
package cond_pkg;

  localparam logic [3:0] COND_EQ    = 4'd0;
  localparam logic [3:0] COND_NE    = 4'd1;
  localparam logic [3:0] COND_CS    = 4'd2;
  localparam logic [3:0] COND_CC    = 4'd3;
  localparam logic [3:0] COND_MI    = 4'd4;
  localparam logic [3:0] COND_PL    = 4'd5;
  localparam logic [3:0] COND_VS    = 4'd6;
  localparam logic [3:0] COND_VC    = 4'd7;
  localparam logic [3:0] COND_HI    = 4'd8;
  localparam logic [3:0] COND_LS    = 4'd9;
  localparam logic [3:0] COND_GE    = 4'd10;
  localparam logic [3:0] COND_LT    = 4'd11;
  localparam logic [3:0] COND_GT    = 4'd12;
  localparam logic [3:0] COND_LE    = 4'd13;
  localparam logic [3:0] COND_AL    = 4'd14;
  localparam logic [3:0] COND_UNDEF = 4'd15;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition check against the current NZCV flags.
// The reserved encoding never passes and raises the undefined-condition trap.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex,
  output logic       undef_cond
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    cond_ex    = 1'b0;
    undef_cond = 1'b0;
    case (cond)
      COND_EQ:    cond_ex = z;
      COND_NE:    cond_ex = ~z;
      COND_CS:    cond_ex = c;
      COND_CC:    cond_ex = ~c;
      COND_MI:    cond_ex = n;
      COND_PL:    cond_ex = ~n;
      COND_VS:    cond_ex = v;
      COND_VC:    cond_ex = ~v;
      COND_HI:    cond_ex = c & ~z;
      COND_LS:    cond_ex = ~(c & ~z);
      COND_GE:    cond_ex = (n == v);
      COND_LT:    cond_ex = (n != v);
      COND_GT:    cond_ex = ~z & (n == v);
      COND_LE:    cond_ex = ~(~z & (n == v));
      COND_AL:    cond_ex = 1'b1;
      COND_UNDEF: undef_cond = 1'b1;
      default:    cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// One-stage conditional-execution unit: evaluates the condition against the
// architectural flags, gates write enables, updates flag groups, counts failures.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int NGRP  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [NGRP-1:0]  FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             UndefCond,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] FailCount
);

  localparam int GW = 4 / NGRP;

  logic       accept;
  logic       cond_ex_d;
  logic       undef_d;
  logic [3:0] flags_q;
  logic [3:0] flags_next;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign Flags    = flags_q;

  cond_eval u_cond_eval (
    .cond       (Cond),
    .flags      (flags_q),
    .cond_ex    (cond_ex_d),
    .undef_cond (undef_d)
  );

  // Each group only takes new flags when its write is requested and the condition passed.
  for (genvar g = 0; g < NGRP; g++) begin : g_flag_grp
    assign flags_next[g*GW +: GW] = (accept & FlagW[g] & cond_ex_d)
                                    ? ALUFlags[g*GW +: GW]
                                    : flags_q[g*GW +: GW];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_next;
  end

  // Draining without a refill only clears out_valid; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
      CondEx    <= 1'b0;
      UndefCond <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      PCSrc     <= PCS  & cond_ex_d;
      RegWrite  <= RegW & cond_ex_d;
      MemWrite  <= MemW & cond_ex_d;
      CondEx    <= cond_ex_d;
      UndefCond <= undef_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      FailCount <= '0;
    end else if (accept & ~undef_d & ~cond_ex_d & (FailCount != {CNT_W{1'b1}})) begin
      FailCount <= FailCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Randomised and directed bench for cond_unit_pipe, checked against a
// cycle-level behavioural model of the handshake, condition table and counter.
module tb_cond_unit_pipe;

  localparam int NGRP  = 2;
  localparam int CNT_W = 2;
  localparam int GW    = 4 / NGRP;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [NGRP-1:0]  flag_w;
  logic             pcs, reg_w, mem_w;
  logic             out_valid;
  logic             out_ready;
  logic             pc_src, reg_write, mem_write, cond_ex, undef_cond;
  logic [3:0]       flags;
  logic [CNT_W-1:0] fail_count;

  int checks   = 0;
  int failures = 0;

  logic       m_valid, m_pcsrc, m_regw, m_memw, m_ex, m_undef;
  logic [3:0] m_flags;
  int         m_fail;

  always #5 clk = ~clk;

  cond_unit_pipe #(.NGRP(NGRP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Cond      (cond),
    .ALUFlags  (alu_flags),
    .FlagW     (flag_w),
    .PCS       (pcs),
    .RegW      (reg_w),
    .MemW      (mem_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .PCSrc     (pc_src),
    .RegWrite  (reg_write),
    .MemWrite  (mem_write),
    .CondEx    (cond_ex),
    .UndefCond (undef_cond),
    .Flags     (flags),
    .FailCount (fail_count)
  );

  // ARM condition table expressed directly on named flags.
  function automatic bit passes(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return cy;
      4'd3:    return !cy;
      4'd4:    return n;
      4'd5:    return !n;
      4'd6:    return v;
      4'd7:    return !v;
      4'd8:    return cy && !z;
      4'd9:    return !(cy && !z);
      4'd10:   return n == v;
      4'd11:   return n != v;
      4'd12:   return !z && (n == v);
      4'd13:   return !(!z && (n == v));
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", {31'b0, out_valid},  {31'b0, m_valid});
    checkOutput("PCSrc",     {31'b0, pc_src},     {31'b0, m_pcsrc});
    checkOutput("RegWrite",  {31'b0, reg_write},  {31'b0, m_regw});
    checkOutput("MemWrite",  {31'b0, mem_write},  {31'b0, m_memw});
    checkOutput("CondEx",    {31'b0, cond_ex},    {31'b0, m_ex});
    checkOutput("UndefCond", {31'b0, undef_cond}, {31'b0, m_undef});
    checkOutput("Flags",     {28'b0, flags},      {28'b0, m_flags});
    checkOutput("FailCount", 32'(fail_count),     32'(m_fail));
  endtask

  // Reset is asserted with a live accept pending to show that reset wins.
  task automatic doReset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; cond = 4'd14;
    alu_flags = 4'b1111; flag_w = '1; pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    m_valid = 0; m_pcsrc = 0; m_regw = 0; m_memw = 0; m_ex = 0; m_undef = 0;
    m_flags = 4'b0000; m_fail = 0;
    checkAll();
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic [3:0] c,
                               input logic [3:0] alu, input logic [NGRP-1:0] fw,
                               input logic p, input logic r, input logic m);
    logic exp_rdy;
    bit   ex;
    in_valid = iv; out_ready = ordy; cond = c; alu_flags = alu;
    flag_w = fw; pcs = p; reg_w = r; mem_w = m;
    #1;
    exp_rdy = !m_valid || ordy;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    @(posedge clk);
    if (iv && exp_rdy) begin
      ex      = (c != 4'd15) && passes(c, m_flags);
      m_undef = (c == 4'd15);
      m_ex    = ex;
      m_pcsrc = p && ex;
      m_regw  = r && ex;
      m_memw  = m && ex;
      for (int i = 0; i < 4; i++)
        if (fw[i / GW] && ex) m_flags[i] = alu[i];
      if (c != 4'd15 && !ex && m_fail < CMAX) m_fail++;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    checkAll();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cond = '0; alu_flags = '0;
    flag_w = '0; pcs = 0; reg_w = 0; mem_w = 0;
    doReset();

    // AL writes all flags, then EQ sees the new Z with no bypass.
    applyStimulus(1, 1, 4'd14, 4'b0100, 2'b11, 0, 1, 0);
    applyStimulus(1, 1, 4'd0,  4'b0000, 2'b00, 0, 0, 1);
    // NE fails: flags untouched, counter bumps.
    applyStimulus(1, 1, 4'd1,  4'b1000, 2'b11, 0, 0, 0);
    // Undefined condition trap.
    applyStimulus(1, 1, 4'd15, 4'b1111, 2'b11, 1, 1, 1);
    // Back-pressure hold, then the queued instruction goes in on release.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'd14, 4'b0011, 2'b11, 1, 1, 1);
    applyStimulus(1, 1, 4'd14, 4'b0011, 2'b11, 1, 1, 1);
    applyStimulus(0, 1, 4'd14, 4'b0000, 2'b00, 0, 0, 0);
    applyStimulus(0, 1, 4'd14, 4'b0000, 2'b00, 0, 0, 0);

    // Group-partial flag write, then GT/LE on N!=V.
    doReset();
    applyStimulus(1, 1, 4'd14, 4'b1111, 2'b10, 0, 0, 0);
    applyStimulus(1, 1, 4'd12, 4'b0000, 2'b00, 0, 1, 0);
    applyStimulus(1, 1, 4'd13, 4'b0000, 2'b00, 0, 1, 0);

    // Counter saturation, then reset while holding.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 4'd0, 4'b0000, 2'b11, 0, 0, 0);
    applyStimulus(1, 0, 4'd1, 4'b0000, 2'b11, 1, 1, 1);
    applyStimulus(1, 0, 4'd1, 4'b0000, 2'b11, 1, 1, 1);
    doReset();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    4'($urandom), 4'($urandom), NGRP'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
      if (i == 200) doReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
